// File: rtl/filtro_pkg.sv
// Shared definitions for the filter datapath: operand select encodings,
// coefficient bank size and accumulator sizing.
package filtro_pkg;

   localparam logic [1:0] FK_X0 = 2'b00;
   localparam logic [1:0] FK_X1 = 2'b01;
   localparam logic [1:0] FK_X2 = 2'b10;
   localparam logic [1:0] FK_Y1 = 2'b11;

   localparam int NUM_COEF = 5;

   // Full product width plus headroom for GUARD accumulations without wrap.
   function automatic int acc_width(input int width, input int guard);
      return 2 * width + guard;
   endfunction

endpackage

// File: rtl/filtro_sat_round.sv
// Round-half-up, arithmetic shift by FRAC and saturation of an accumulator
// value into a WIDTH-bit signed result with a clip flag.
module filtro_sat_round #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int AW    = 35
) (
   input  logic [AW-1:0]    acc_i,
   output logic [WIDTH-1:0] y_o,
   output logic             clip_o
);

   localparam logic signed [AW:0] HALF  = (AW + 1)'(1) << (FRAC - 1);
   localparam logic signed [AW:0] MAX_V = {{(AW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [AW:0] MIN_V = {{(AW + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

   logic signed [AW:0] sum;
   logic signed [AW:0] shr;

   // One extra bit so adding the rounding constant can never wrap.
   assign sum = $signed({acc_i[AW-1], acc_i}) + HALF;
   assign shr = sum >>> FRAC;

   always_comb begin
      y_o    = shr[WIDTH-1:0];
      clip_o = 1'b0;
      if (shr > MAX_V) begin
         y_o    = MAX_V[WIDTH-1:0];
         clip_o = 1'b1;
      end else if (shr < MIN_V) begin
         y_o    = MIN_V[WIDTH-1:0];
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/filtro_datapath.sv
// Filter arithmetic datapath: sample/feedback history, coefficient bank and a
// signed MAC stepped by the external controller; one rounded output per sequence.
module filtro_datapath
   import filtro_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int GUARD = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bandera,
   input  logic [WIDTH-1:0] muestra_in,
   input  logic             paso,
   input  logic [2:0]       Sel_cons,
   input  logic [1:0]       Sel_fk,
   input  logic             Sel_ac,
   input  logic             listo,
   input  logic             coef_we,
   input  logic [2:0]       coef_addr,
   input  logic [WIDTH-1:0] coef_data,
   output logic [WIDTH-1:0] y_out,
   output logic             y_valid,
   output logic             sat
);

   localparam int AW = acc_width(WIDTH, GUARD);

   logic signed [WIDTH-1:0]       x0_q, x1_q, x2_q, y1_q;
   logic signed [AW-1:0]          acc_q, acc_d, acc_mac, prod_ext;
   logic signed [2*WIDTH-1:0]     prod;
   logic signed [WIDTH-1:0]       operand, coef_sel;
   logic [NUM_COEF*WIDTH-1:0]     coef_flat;
   logic [WIDTH-1:0]              y_out_q, rnd_y;
   logic                          sat_q, y_valid_q, rnd_clip;

   for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
      logic [WIDTH-1:0] c_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            c_q <= '0;
         end else if (coef_we && coef_addr == 3'(gi)) begin
            c_q <= coef_data;
         end
      end
      assign coef_flat[gi*WIDTH +: WIDTH] = c_q;
   end

   always_comb begin
      operand = x0_q;
      case (Sel_fk)
         FK_X0: operand = x0_q;
         FK_X1: operand = x1_q;
         FK_X2: operand = x2_q;
         FK_Y1: operand = y1_q;
      endcase
   end

   // Selects beyond the bank read as a zero coefficient.
   always_comb begin
      coef_sel = '0;
      for (int i = 0; i < NUM_COEF; i++) begin
         if (Sel_cons == 3'(i)) coef_sel = $signed(coef_flat[i*WIDTH +: WIDTH]);
      end
   end

   assign prod     = operand * coef_sel;
   assign prod_ext = AW'(prod);
   assign acc_mac  = Sel_ac ? acc_q + prod_ext : prod_ext;
   assign acc_d    = paso ? acc_mac : acc_q;

   filtro_sat_round #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .AW    (AW)
   ) u_sat_round (
      .acc_i  (acc_mac),
      .y_o    (rnd_y),
      .clip_o (rnd_clip)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q      <= '0;
         x1_q      <= '0;
         x2_q      <= '0;
         y1_q      <= '0;
         acc_q     <= '0;
         y_out_q   <= '0;
         sat_q     <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         y_valid_q <= paso && listo;
         if (bandera) begin
            x2_q <= x1_q;
            x1_q <= x0_q;
            x0_q <= muestra_in;
         end
         if (paso && listo) begin
            y_out_q <= rnd_y;
            sat_q   <= rnd_clip;
            y1_q    <= rnd_y;
         end
      end
   end

   assign y_out   = y_out_q;
   assign y_valid = y_valid_q;
   assign sat     = sat_q;

endmodule

// File: tb/tb_filtro_datapath.sv
// Self-checking bench for filtro_datapath: directed scenarios plus random
// stimulus compared each cycle against a plain-arithmetic reference model.
module tb_filtro_datapath;

   logic        clk = 1'b0;
   logic        rst, bandera, paso, Sel_ac, listo, coef_we;
   logic [15:0] muestra_in, coef_data, y_out;
   logic [2:0]  Sel_cons, coef_addr;
   logic [1:0]  Sel_fk;
   logic        y_valid, sat;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int     mx[3];
   int     mc[5];
   int     my1, ey, esat, evalid;
   longint macc;

   always #5 clk = ~clk;

   filtro_datapath #(.WIDTH(16), .FRAC(8), .GUARD(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .bandera    (bandera),
      .muestra_in (muestra_in),
      .paso       (paso),
      .Sel_cons   (Sel_cons),
      .Sel_fk     (Sel_fk),
      .Sel_ac     (Sel_ac),
      .listo      (listo),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .y_out      (y_out),
      .y_valid    (y_valid),
      .sat        (sat)
   );

   function automatic longint wrap35(input longint v);
      return (v <<< 29) >>> 29;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      rst = 0; bandera = 0; muestra_in = 0; paso = 0; Sel_cons = 0; Sel_fk = 0;
      Sel_ac = 0; listo = 0; coef_we = 0; coef_addr = 0; coef_data = 0;
   endtask

   // Advance the model with the currently driven inputs, clock the DUT, compare.
   task automatic tick();
      longint p, a, r;
      int     opd, cf;
      if (rst) begin
         mx = '{0, 0, 0};
         mc = '{0, 0, 0, 0, 0};
         my1 = 0; macc = 0; ey = 0; esat = 0; evalid = 0;
      end else begin
         evalid = 0;
         if (paso) begin
            case (Sel_fk)
               2'd0: opd = mx[0];
               2'd1: opd = mx[1];
               2'd2: opd = mx[2];
               default: opd = my1;
            endcase
            cf = (Sel_cons < 5) ? mc[Sel_cons] : 0;
            p = longint'(opd) * longint'(cf);
            a = wrap35(Sel_ac ? macc + p : p);
            macc = a;
            if (listo) begin
               r = (a + 128) >>> 8;
               esat = 0;
               if (r > 32767) begin r = 32767; esat = 1; end
               else if (r < -32768) begin r = -32768; esat = 1; end
               ey = int'(r);
               my1 = ey;
               evalid = 1;
            end
         end
         if (coef_we && coef_addr < 5) mc[coef_addr] = int'($signed(coef_data));
         if (bandera) begin
            mx[2] = mx[1];
            mx[1] = mx[0];
            mx[0] = int'($signed(muestra_in));
         end
      end
      @(posedge clk);
      #1;
      chk("y_out", int'(y_out), int'(ey[15:0]));
      chk("y_valid", int'(y_valid), evalid);
      chk("sat", int'(sat), esat);
      if (evalid != 0)
         $display("result: y_out=%h sat=%b (model %h)", y_out, sat, ey[15:0]);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         rst = 1; bandera = 1'($urandom); muestra_in = 16'($urandom);
         paso = 1'($urandom); Sel_cons = 3'($urandom); Sel_fk = 2'($urandom);
         Sel_ac = 1'($urandom); listo = 1'($urandom); coef_we = 1'($urandom);
         coef_addr = 3'($urandom); coef_data = 16'($urandom);
         tick();
      end
      set_idle();
   endtask

   task automatic write_coef(input int addr, input int data);
      set_idle();
      coef_we = 1; coef_addr = 3'(addr); coef_data = 16'(data);
      tick();
      set_idle();
   endtask

   task automatic sample(input int v);
      set_idle();
      bandera = 1; muestra_in = 16'(v);
      tick();
      set_idle();
   endtask

   task automatic set_step(input int k);
      paso = 1; Sel_cons = 3'(k); Sel_fk = 2'(k); Sel_ac = (k != 0); listo = (k == 3);
   endtask

   task automatic run_seq();
      for (int k = 0; k < 4; k++) begin
         set_idle();
         set_step(k);
         tick();
      end
      set_idle();
   endtask

   task automatic expect_result(input string name, input int y, input int s);
      chk({name, "_y"}, int'(y_out), y);
      chk({name, "_model"}, int'(ey[15:0]), y);
      chk({name, "_valid"}, int'(y_valid), 1);
      chk({name, "_sat"}, int'(sat), s);
   endtask

   initial begin
      int avg_exp[3];
      int fb_exp[4];
      avg_exp = '{'h0080, 'h0100, 'h0180};
      fb_exp  = '{'h0100, 'h0080, 'h0040, 'h0020};
      set_idle();

      // reset state and an all-zero sequence
      do_reset();
      chk("reset_y", int'(y_out), 0);
      chk("reset_valid", int'(y_valid), 0);
      chk("reset_sat", int'(sat), 0);
      run_seq();
      expect_result("zero", 'h0000, 0);

      // identity
      do_reset();
      write_coef(0, 'h0100);
      sample('h0200);
      run_seq();
      expect_result("ident", 'h0200, 0);
      tick();
      chk("ident_pulse_end", int'(y_valid), 0);

      // 3-tap average
      do_reset();
      for (int i = 0; i < 3; i++) write_coef(i, 'h0080);
      for (int i = 0; i < 3; i++) begin
         sample('h0100);
         run_seq();
         expect_result("avg", avg_exp[i], 0);
      end

      // feedback decay
      do_reset();
      write_coef(0, 'h0100);
      write_coef(3, 'h0080);
      for (int i = 0; i < 4; i++) begin
         sample(i == 0 ? 'h0100 : 0);
         run_seq();
         expect_result("fb", fb_exp[i], 0);
      end

      // saturation and rounding
      do_reset(); write_coef(0, 'h7FFF); sample('h7FFF); run_seq();
      expect_result("sat_pos", 'h7FFF, 1);
      do_reset(); write_coef(0, 'h8000); sample('h7FFF); run_seq();
      expect_result("sat_neg", 'h8000, 1);
      do_reset(); write_coef(0, 'h0001); sample('h0080); run_seq();
      expect_result("round", 'h0001, 0);

      // collisions: shift and coefficient write land on the first step
      do_reset();
      write_coef(0, 'h0100);
      sample('h0200);
      set_step(0);
      bandera = 1; muestra_in = 16'h0300;
      coef_we = 1; coef_addr = 0; coef_data = 16'h0200;
      tick();
      for (int k = 1; k < 4; k++) begin
         set_idle(); set_step(k); tick();
      end
      set_idle();
      expect_result("collide", 'h0200, 0);

      // reset in the middle of a sequence: no result for the aborted run
      for (int k = 0; k < 2; k++) begin
         set_idle(); set_step(k); tick();
      end
      set_idle(); rst = 1; tick();
      set_idle(); tick();
      chk("abort_valid", int'(y_valid), 0);
      chk("abort_y", int'(y_out), 0);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 39) == 0);
         bandera    = ($urandom_range(0, 3) == 0);
         muestra_in = 16'($urandom);
         paso       = ($urandom_range(0, 1) == 0);
         Sel_cons   = 3'($urandom);
         Sel_fk     = 2'($urandom);
         Sel_ac     = 1'($urandom);
         listo      = ($urandom_range(0, 3) == 0);
         coef_we    = ($urandom_range(0, 5) == 0);
         coef_addr  = 3'($urandom);
         coef_data  = 16'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/filtro_datapath.md
Name: filtro_datapath

Overview:
- Arithmetic datapath for the filter block. It executes one signed multiply-accumulate per step command from the filter control FSM, using the select lines that controller drives (Sel_cons, Sel_fk, Sel_ac, listo).
- Holds the sample history, the output feedback history and a programmable coefficient bank.
- Produces one saturated fixed-point output sample per completed sequence.

Parameters:
- WIDTH, 16, signed sample/coefficient width (two's complement).
- FRAC, 8, fractional bits of samples/coefficients (Q(WIDTH-FRAC).FRAC); requires 1 <= FRAC < WIDTH.
- GUARD, 3, accumulator guard bits; accumulator width = 2*WIDTH+GUARD.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- bandera  in  1  one-cycle new-sample strobe; captures muestra_in.
- muestra_in  in  WIDTH  signed input sample.
- paso  in  1  step strobe; one MAC executes in each cycle it is high.
- Sel_cons  in  3  coefficient select 0..4; values 5..7 select coefficient 0 (zero).
- Sel_fk  in  2  operand select: 00 x[n], 01 x[n-1], 10 x[n-2], 11 y[n-1].
- Sel_ac  in  1  0: acc <= product; 1: acc <= acc + product.
- listo  in  1  qualifies the current paso as the final step of the sequence.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  3  coefficient index 0..4; writes to 5..7 are ignored.
- coef_data  in  WIDTH  signed coefficient value.
- y_out  out  WIDTH  signed filter output, held until next result.
- y_valid  out  1  one-cycle pulse when y_out updates.
- sat  out  1  high with y_valid if that result saturated; held with y_out.

Behaviour:
- Reset (rst=1 at clk edge): x0, x1, x2, y1, acc, coef[0..4], y_out, sat all 0; y_valid 0; rst overrides every other input in that cycle.
- Sample capture: bandera=1 -> x2<=x1, x1<=x0, x0<=muestra_in. Back-to-back bandera pulses shift every cycle.
- MAC step, when paso=1:
  - operand = Sel_fk mux; coefficient = coef[Sel_cons], or 0 if Sel_cons>4.
  - product = full signed 2*WIDTH bits, sign-extended to accumulator width.
  - acc <= Sel_ac ? acc+product : product.
  - The accumulator wraps in two's complement; GUARD bits make wrap impossible for at most 2^GUARD steps.
  - paso=0 -> acc holds; Sel_ac, Sel_cons, Sel_fk and listo are don't-care.
- Final step, when paso=1 and listo=1:
  - acc_next = the value acc is written with in that cycle.
  - r = (acc_next + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up).
  - Next edge: y_out <= saturate(r) to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat <= 1 if clipped, else 0; y1 <= saturated value; y_valid=1 for exactly that one cycle.
  - Latency: y_valid asserts 1 cycle after the final paso edge.
- listo=1 with paso=0: ignored, no output.
- Simultaneous events:
  - bandera and paso in the same cycle: the MAC uses pre-shift x values; the shift takes effect after the edge.
  - coef_we and paso in the same cycle with the same index: the MAC uses the old coefficient; the new value is visible next cycle.
  - Final step with Sel_fk=11: uses the old y1; y1 updates after the edge.
- Reset mid-sequence: partial acc is discarded, no y_valid; coefficients return to 0 and must be reloaded.
- No internal FSM: the sequence order is owned by the controller. The datapath is registered pipeline/state only (history shift register, accumulator, output register, coefficient bank).

Decomposition:
- Shared package filtro_pkg:
  - Sel_fk encodings FK_X0=2'b00, FK_X1=2'b01, FK_X2=2'b10, FK_Y1=2'b11.
  - NUM_COEF=5.
  - Accumulator-width function of WIDTH and GUARD.
- Sub-module filtro_sat_round: combinational round-half-up, shift by FRAC, saturate to WIDTH; outputs value and clip flag. Reused by later filter stages.

Test Plan:
All scenarios use WIDTH=16, FRAC=8, GUARD=3 and the step sequence (Sel_cons,Sel_fk,Sel_ac) = (0,00,0), (1,01,1), (2,10,1), (3,11,1), with listo on the 4th step.
- Reset: hold rst 2 cycles with random inputs -> y_out=0, y_valid=0, sat=0; a sequence with no coefficient writes yields y_out=0x0000.
- Identity: coef0=0x0100, others 0; bandera with 0x0200 -> y_out=0x0200, y_valid one cycle after the listo step, sat=0.
- 3-tap average: coef0..2=0x0080; bandera 0x0100 three times, run a sequence after each -> y_out=0x0080, 0x0100, 0x0180.
- Feedback: coef0=0x0100, coef3=0x0080; single 0x0100 sample then zeros -> y_out=0x0100, 0x0080, 0x0040, 0x0020.
- Saturation and rounding:
  - coef0=0x7FFF, x=0x7FFF -> y_out=0x7FFF, sat=1.
  - coef0=0x8000, x=0x7FFF -> y_out=0x8000, sat=1.
  - coef0=0x0001, x=0x0080 -> y_out=0x0001 (rounds up), sat=0.
- Collisions: bandera and coef_we to coef0 land on the first paso; rst asserted mid-sequence -> the MAC uses old x/coef values; after reset no y_valid occurs for the aborted sequence.
